// File: rtl/line_mem_ctrl_if.sv
// Request/response bundle between a line initiator and line_mem_ctrl.
// err_o exists only when LINE_MEM_BOUNDS_CHECK_EN is defined.
interface line_mem_ctrl_if #(
  parameter int PADDR_WIDTH = 20,
  parameter int LINE_BYTES  = 16
);
  logic                      req_i;
  logic                      we_i;
  logic [PADDR_WIDTH-1:0]    addr_i;
  logic [LINE_BYTES*8-1:0]   wdata_i;
  logic                      gnt_o;
  logic                      rvalid_o;
  logic [LINE_BYTES*8-1:0]   rdata_o;
  logic                      write_done_o;
  logic                      busy_o;
`ifdef LINE_MEM_BOUNDS_CHECK_EN
  logic                      err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  write_done_o, busy_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output write_done_o, busy_o, err_o
  );
`else
  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  write_done_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output write_done_o, busy_o
  );
`endif
endinterface

// File: rtl/line_mem_ctrl.sv
// Single-port line memory with fixed read/write latency, one op in flight.
// Optional: LINE_MEM_BOUNDS_CHECK_EN flags (and blocks) addresses above the index field.
module line_mem_ctrl #(
  parameter int PADDR_WIDTH = 20,
  parameter int LINE_BYTES  = 16,
  parameter int MEM_LINES   = 256,
  parameter int RD_LATENCY  = 4,
  parameter int WR_LATENCY  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  line_mem_ctrl_if.slave     bus
);
  localparam int DW      = LINE_BYTES * 8;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam int HI_LSB  = OFF_W + IDX_W;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic [DW-1:0]    r_mem [MEM_LINES];

  logic             w_gnt;
  logic             w_rvalid;
  logic             w_wdone;
  logic             w_busy;
  logic             w_commit;
  logic [IDX_W-1:0] w_idx;
  logic [DW-1:0]    w_rd_line;

  assign w_idx = bus.addr_i[OFF_W +: IDX_W];

`ifdef LINE_MEM_BOUNDS_CHECK_EN
  logic r_err;
  logic w_oob;
  logic w_unused_addr;

  assign w_oob         = |bus.addr_i[PADDR_WIDTH-1:HI_LSB];
  assign w_unused_addr = &{1'b0, bus.addr_i[OFF_W-1:0]};
  assign w_rd_line     = r_err ? '0 : r_mem[r_idx];
  assign w_commit      = w_wdone && !r_err;
  assign bus.err_o     = (w_rvalid || w_wdone) && r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_gnt) begin
      r_err <= w_oob;
    end
  end
`else
  logic w_unused_addr;

  // Upper bits simply alias onto the index field.
  assign w_unused_addr = &{1'b0, bus.addr_i[OFF_W-1:0],
                           bus.addr_i[PADDR_WIDTH-1:HI_LSB]};
  assign w_rd_line     = r_mem[r_idx];
  assign w_commit      = w_wdone;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_idx   <= w_idx;
        r_wdata <= bus.wdata_i;
        r_cnt   <= bus.we_i ? WR_LOAD : RD_LOAD;
      end else if (w_busy && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rvalid) begin
        r_rdata <= w_rd_line;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_next = bus.we_i ? S_WR_WAIT : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt    = 1'b0;
    w_rvalid = 1'b0;
    w_wdone  = 1'b0;
    w_busy   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt = bus.req_i && !rst_i;
      end
      S_RD_WAIT: begin
        w_busy   = 1'b1;
        w_rvalid = (r_cnt == '0);
      end
      S_WR_WAIT: begin
        w_busy  = 1'b1;
        w_wdone = (r_cnt == '0);
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Array is deliberately unreset; a reset-aborted write never reaches it.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.gnt_o        = w_gnt;
  assign bus.rvalid_o     = w_rvalid;
  assign bus.write_done_o = w_wdone;
  assign bus.busy_o       = w_busy;
  assign bus.rdata_o      = w_rvalid ? w_rd_line : r_rdata;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench for line_mem_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares kind, timing, data (and err).
module tb_line_mem_ctrl;
  localparam int PAW = 20;
  localparam int LB  = 16;
  localparam int DW  = LB * 8;
  localparam int LAT = 4;

  localparam logic [DW-1:0] D0 = 128'h00000000_11111111_22222222_33333333;
  localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D2 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [DW-1:0] D3 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [DW-1:0] D4 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

`ifdef LINE_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam logic [DW-1:0] LINE4_FINAL = BOUNDS ? D1 : D3;

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
    int            due;
    bit            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  line_mem_ctrl_if #(.PADDR_WIDTH(PAW), .LINE_BYTES(LB)) bus ();

  line_mem_ctrl #(
    .PADDR_WIDTH(PAW),
    .LINE_BYTES (LB),
    .MEM_LINES  (256),
    .RD_LATENCY (LAT),
    .WR_LATENCY (LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.rvalid_o || bus.write_done_o)) begin
      chk("pulse_exclusive", DW'(bus.rvalid_o & bus.write_done_o), '0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: rvalid=%b write_done=%b at cycle %0d, expected none",
                 bus.rvalid_o, bus.write_done_o, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_kind", DW'(bus.rvalid_o), DW'(mon_e.rd));
        chk("pulse_cycle", DW'(cyc), DW'(mon_e.due));
        if (mon_e.rd) chk("rdata", bus.rdata_o, mon_e.data);
`ifdef LINE_MEM_BOUNDS_CHECK_EN
        chk("err", DW'(bus.err_o), DW'(mon_e.err));
`endif
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input bit we, input logic [PAW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                       input bit err, input bit perturb);
    @(posedge clk); #1;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = a;
    bus.wdata_i = wd;
    @(negedge clk);
    chk("gnt_same_cycle", DW'(bus.gnt_o), DW'(1));
    if (bus.gnt_o) q.push_back('{rd: !we, data: exp, due: cyc + LAT, err: err});
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    if (perturb) begin
      bus.addr_i  = a ^ 20'h00080;
      bus.wdata_i = ~wd;
    end
    drain();
  endtask

  initial begin
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", DW'(bus.gnt_o), '0);
    chk("rst_rvalid", DW'(bus.rvalid_o), '0);
    chk("rst_wdone", DW'(bus.write_done_o), '0);
    chk("rst_busy", DW'(bus.busy_o), '0);
    chk("rst_rdata", bus.rdata_o, '0);
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    issue(1'b1, 20'h00040, D1, D1, 1'b0, 1'b0);
    issue(1'b0, 20'h00040, '0, D1, 1'b0, 1'b0);
    issue(1'b1, 20'h00080, D0, D0, 1'b0, 1'b0);
    chk("rdata_hold", bus.rdata_o, D1);

    // req held through a read: blocked while busy, regranted right after
    @(posedge clk); #1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 20'h00040;
    @(negedge clk);
    chk("held_gnt0", DW'(bus.gnt_o), DW'(1));
    q.push_back('{rd: 1'b1, data: D1, due: cyc + LAT, err: 1'b0});
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) bus.addr_i = 20'h00080;
      chk("held_gnt_blocked", DW'(bus.gnt_o), '0);
      chk("held_busy", DW'(bus.busy_o), DW'(1));
    end
    @(negedge clk);
    chk("held_regrant", DW'(bus.gnt_o), DW'(1));
    if (bus.gnt_o) q.push_back('{rd: 1'b1, data: D0, due: cyc + LAT, err: 1'b0});
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    drain();

    // write aborted by reset two cycles after grant
    @(posedge clk); #1;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 20'h00080;
    bus.wdata_i = D2;
    @(negedge clk);
    chk("abort_gnt", DW'(bus.gnt_o), DW'(1));
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("abort_busy", DW'(bus.busy_o), '0);
    chk("abort_rdata", bus.rdata_o, '0);
    #5;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    issue(1'b0, 20'h00080, '0, D0, 1'b0, 1'b0);

    issue(1'b0, 20'h0004C, '0, D1, 1'b0, 1'b0);
    issue(1'b0, 20'h01040, '0, BOUNDS ? '0 : D1, BOUNDS, 1'b0);
    issue(1'b1, 20'h01040, D3, D3, BOUNDS, 1'b0);
    issue(1'b0, 20'h00040, '0, LINE4_FINAL, 1'b0, 1'b0);

    issue(1'b1, 20'h000C0, D4, D4, 1'b0, 1'b1);
    issue(1'b0, 20'h000C0, '0, D4, 1'b0, 1'b1);
    issue(1'b0, 20'h00040, '0, LINE4_FINAL, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
